// File: rtl/abz_speed_meas_pkg.sv
// Shared definitions for the ABZ speed measurement block: FSM encoding and
// the single-step values used to tell ordinary motion from count loads.
package abz_speed_meas_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Legal per-clock steps of the upstream counter; -1 becomes all-ones once sized.
  localparam int STEP_UP = 1;
  localparam int STEP_DN = -1;

endpackage

// File: rtl/abz_speed_meas_if.sv
// Signal bundle between the position-count source/consumer and abz_speed_meas.
interface abz_speed_meas_if #(
  parameter int BIT_LENGTH = 12,
  parameter int WIN_WIDTH  = 16,
  parameter int PER_WIDTH  = 20
);
  logic        [BIT_LENGTH-1:0] CNT_IN;
  logic                         EN_IN;
  logic                         CLR_IN;
  logic        [WIN_WIDTH-1:0]  WINDOW_CYCLES;
  logic signed [BIT_LENGTH-1:0] SPEED_OUT;
  logic                         SPEED_VALID;
  logic        [PER_WIDTH-1:0]  PERIOD_OUT;
  logic                         PERIOD_VALID;
  logic                         DIR_OUT;
  logic                         STALL_OUT;
  logic                         JUMP_OUT;

  modport master (
    output CNT_IN, EN_IN, CLR_IN, WINDOW_CYCLES,
    input  SPEED_OUT, SPEED_VALID, PERIOD_OUT, PERIOD_VALID, DIR_OUT, STALL_OUT, JUMP_OUT
  );

  modport slave (
    input  CNT_IN, EN_IN, CLR_IN, WINDOW_CYCLES,
    output SPEED_OUT, SPEED_VALID, PERIOD_OUT, PERIOD_VALID, DIR_OUT, STALL_OUT, JUMP_OUT
  );
endinterface

// File: rtl/abz_speed_meas_period.sv
// T-method: cycles between consecutive single-step count changes, with
// direction of the last step and a stall flag once the counter saturates.
module abz_period_meas #(
  parameter int PER_WIDTH = 20
) (
  input  logic                 CLK,
  input  logic                 ARSTN,
  input  logic                 run,
  input  logic                 clr,
  input  logic                 change,
  input  logic                 jump,
  input  logic                 step_up,
  output logic [PER_WIDTH-1:0] period_out,
  output logic                 period_valid,
  output logic                 dir_out,
  output logic                 stall_out
);
  import abz_speed_meas_pkg::*;

  logic [PER_WIDTH-1:0] pcnt_q;
  logic                 armed_q;
  logic [PER_WIDTH-1:0] pcnt_inc;

  function automatic logic [PER_WIDTH-1:0] sat_inc(input logic [PER_WIDTH-1:0] v);
    return (&v) ? v : v + PER_WIDTH'(1);
  endfunction

  assign pcnt_inc = sat_inc(pcnt_q);

  always_ff @(posedge CLK or negedge ARSTN) begin
    if (!ARSTN) begin
      pcnt_q       <= '0;
      armed_q      <= 1'b0;
      period_out   <= '0;
      period_valid <= 1'b0;
      dir_out      <= 1'b0;
      stall_out    <= 1'b0;
    end else begin
      period_valid <= 1'b0;
      if (clr) begin
        pcnt_q     <= '0;
        armed_q    <= 1'b0;
        period_out <= '0;
        dir_out    <= 1'b0;
        stall_out  <= 1'b0;
      end else if (!run) begin
        // Leaving or outside RUN: next entry starts unarmed; outputs hold.
        pcnt_q  <= '0;
        armed_q <= 1'b0;
      end else if (jump) begin
        pcnt_q    <= '0;
        armed_q   <= 1'b0;
        stall_out <= 1'b0;
      end else if (change) begin
        dir_out   <= step_up;
        pcnt_q    <= PER_WIDTH'(1);
        armed_q   <= 1'b1;
        stall_out <= 1'b0;
        if (armed_q) begin
          period_out   <= pcnt_q;
          period_valid <= 1'b1;
        end
      end else begin
        pcnt_q    <= pcnt_inc;
        stall_out <= &pcnt_inc;
      end
    end
  end

endmodule

// File: rtl/abz_speed_meas.sv
// Speed measurement on a quadrature position count: windowed count delta
// (M-method) plus inter-change period (T-method), with load/jump rejection.
module abz_speed_meas #(
  parameter int BIT_LENGTH = 12,
  parameter int WIN_WIDTH  = 16,
  parameter int PER_WIDTH  = 20
) (
  input  logic              CLK,
  input  logic              ARSTN,
  abz_speed_meas_if.slave   bus
);
  import abz_speed_meas_pkg::*;

  localparam logic [BIT_LENGTH-1:0] STEP_P1 = BIT_LENGTH'(STEP_UP);
  localparam logic [BIT_LENGTH-1:0] STEP_M1 = BIT_LENGTH'(STEP_DN);

  logic        [BIT_LENGTH-1:0] cnt_q;
  logic        [BIT_LENGTH-1:0] ref_q;
  logic        [BIT_LENGTH-1:0] step;
  logic                         change;
  logic                         jump;
  logic        [WIN_WIDTH-1:0]  wcnt_q;
  logic        [WIN_WIDTH-1:0]  win_load;
  logic                         win_end;
  logic signed [BIT_LENGTH-1:0] speed_q;
  logic                         speed_vld_q;
  logic                         jump_q;
  state_t                       state_q, state_d;
  logic                         enter;
  logic                         run_act;

  function automatic logic [WIN_WIDTH-1:0] win_len(input logic [WIN_WIDTH-1:0] w);
    return (w == '0) ? WIN_WIDTH'(1) : w;
  endfunction

  function automatic logic signed [BIT_LENGTH-1:0] cnt_delta(
    input logic [BIT_LENGTH-1:0] a,
    input logic [BIT_LENGTH-1:0] b
  );
    return $signed(a - b);
  endfunction

  assign step     = bus.CNT_IN - cnt_q;
  assign change   = (step != '0);
  assign jump     = change && (step != STEP_P1) && (step != STEP_M1);
  assign win_load = win_len(bus.WINDOW_CYCLES);
  assign win_end  = (wcnt_q == WIN_WIDTH'(1));

  always_ff @(posedge CLK or negedge ARSTN) begin
    if (!ARSTN) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (bus.CLR_IN) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (bus.EN_IN)  state_d = ST_RUN;
        ST_RUN:  if (!bus.EN_IN) state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Exit edges (EN low or clear) produce no events at all.
  always_comb begin
    enter   = 1'b0;
    run_act = 1'b0;
    if (!bus.CLR_IN && bus.EN_IN) begin
      enter   = (state_q == ST_IDLE);
      run_act = (state_q == ST_RUN);
    end
  end

  always_ff @(posedge CLK or negedge ARSTN) begin
    if (!ARSTN) begin
      cnt_q       <= '0;
      ref_q       <= '0;
      wcnt_q      <= '0;
      speed_q     <= '0;
      speed_vld_q <= 1'b0;
      jump_q      <= 1'b0;
    end else begin
      cnt_q       <= bus.CNT_IN;
      speed_vld_q <= 1'b0;
      jump_q      <= 1'b0;
      if (bus.CLR_IN) begin
        ref_q   <= '0;
        wcnt_q  <= '0;
        speed_q <= '0;
      end else if (enter) begin
        ref_q  <= bus.CNT_IN;
        wcnt_q <= win_load;
      end else if (run_act) begin
        if (jump) begin
          jump_q <= 1'b1;
          ref_q  <= bus.CNT_IN;
          wcnt_q <= win_load;
        end else if (win_end) begin
          speed_q     <= cnt_delta(bus.CNT_IN, ref_q);
          speed_vld_q <= 1'b1;
          ref_q       <= bus.CNT_IN;
          wcnt_q      <= win_load;
        end else begin
          wcnt_q <= wcnt_q - WIN_WIDTH'(1);
        end
      end
    end
  end

  abz_period_meas #(.PER_WIDTH(PER_WIDTH)) u_period (
    .CLK          (CLK),
    .ARSTN        (ARSTN),
    .run          (run_act),
    .clr          (bus.CLR_IN),
    .change       (change),
    .jump         (jump),
    .step_up      (step == STEP_P1),
    .period_out   (bus.PERIOD_OUT),
    .period_valid (bus.PERIOD_VALID),
    .dir_out      (bus.DIR_OUT),
    .stall_out    (bus.STALL_OUT)
  );

  assign bus.SPEED_OUT   = speed_q;
  assign bus.SPEED_VALID = speed_vld_q;
  assign bus.JUMP_OUT    = jump_q;

endmodule

// File: tb/tb_abz_speed_meas.sv
// Directed bench for abz_speed_meas (PER_WIDTH=8 build so the stall case is short).
module tb_abz_speed_meas;
  localparam int BL = 12;
  localparam int WW = 16;
  localparam int PW = 8;

  logic CLK   = 1'b0;
  logic ARSTN = 1'b0;

  abz_speed_meas_if #(.BIT_LENGTH(BL), .WIN_WIDTH(WW), .PER_WIDTH(PW)) bus ();

  abz_speed_meas #(.BIT_LENGTH(BL), .WIN_WIDTH(WW), .PER_WIDTH(PW)) dut (
    .CLK   (CLK),
    .ARSTN (ARSTN),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;
  int spd_cnt, per_cnt, jmp_cnt;
  logic [BL-1:0] last_spd;
  logic [PW-1:0] last_per;
  logic [BL-1:0] cnt;

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clr_stats();
    spd_cnt = 0;
    per_cnt = 0;
    jmp_cnt = 0;
  endtask

  // One active edge, then sample 1 ns later and accumulate strobe statistics.
  task automatic tick();
    @(posedge CLK);
    #1;
    if (bus.SPEED_VALID)  begin spd_cnt++; last_spd = bus.SPEED_OUT; end
    if (bus.PERIOD_VALID) begin per_cnt++; last_per = bus.PERIOD_OUT; end
    if (bus.JUMP_OUT)     jmp_cnt++;
  endtask

  task automatic check_all_zero(input string tag);
    logic [BL-1:0] s;
    s = bus.SPEED_OUT;
    check_eq({tag, "_speed"},  s, 0);
    check_eq({tag, "_svld"},   bus.SPEED_VALID, 0);
    check_eq({tag, "_period"}, bus.PERIOD_OUT, 0);
    check_eq({tag, "_pvld"},   bus.PERIOD_VALID, 0);
    check_eq({tag, "_dir"},    bus.DIR_OUT, 0);
    check_eq({tag, "_stall"},  bus.STALL_OUT, 0);
    check_eq({tag, "_jump"},   bus.JUMP_OUT, 0);
  endtask

  initial begin
    cnt               = '0;
    bus.CNT_IN        = '0;
    bus.EN_IN         = 1'b0;
    bus.CLR_IN        = 1'b0;
    bus.WINDOW_CYCLES = 16'd100;
    clr_stats();
    last_spd = '0;
    last_per = '0;

    repeat (3) tick();
    check_all_zero("reset");
    ARSTN = 1'b1;
    repeat (2) tick();

    // Slow forward motion: +1 every 10 cycles, 100-cycle windows.
    clr_stats();
    bus.EN_IN = 1'b1;
    for (int i = 0; i < 300; i++) begin
      tick();
      if ((i + 1) % 10 == 0) begin cnt++; bus.CNT_IN = cnt; end
    end
    check_eq("t1_spd_cnt", spd_cnt, 2);
    check_eq("t1_speed",   last_spd, 10);
    check_eq("t1_per_cnt", per_cnt, 28);
    check_eq("t1_period",  last_per, 10);
    check_eq("t1_dir",     bus.DIR_OUT, 1);
    check_eq("t1_jumps",   jmp_cnt, 0);
    bus.EN_IN = 1'b0;
    tick();

    // Reverse motion through the 0 -> 4095 wrap.
    cnt = 12'd5; bus.CNT_IN = cnt; bus.WINDOW_CYCLES = 16'd40;
    repeat (2) tick();
    clr_stats();
    bus.EN_IN = 1'b1;
    for (int i = 0; i < 120; i++) begin
      tick();
      if ((i + 1) % 4 == 0) begin cnt--; bus.CNT_IN = cnt; end
    end
    check_eq("t2_spd_cnt", spd_cnt, 2);
    check_eq("t2_speed",   last_spd, 12'hFF6);
    check_eq("t2_per_cnt", per_cnt, 28);
    check_eq("t2_period",  last_per, 4);
    check_eq("t2_dir",     bus.DIR_OUT, 0);
    check_eq("t2_jumps",   jmp_cnt, 0);
    bus.EN_IN = 1'b0;
    tick();

    // Mid-window load 51 -> 2000 restarts the window and disarms the period.
    cnt = 12'd50; bus.CNT_IN = cnt; bus.WINDOW_CYCLES = 16'd30;
    repeat (2) tick();
    clr_stats();
    bus.EN_IN = 1'b1;
    for (int i = 0; i <= 40; i++) begin
      tick();
      if (i == 10) check_eq("t3_jump_pulse", bus.JUMP_OUT, 1);
      if (i == 11) check_eq("t3_jump_one",   bus.JUMP_OUT, 0);
      if (i == 15) check_eq("t3_rearm_nopv", per_cnt, 0);
      if (i == 25) begin
        check_eq("t3_pv_after2", per_cnt, 1);
        check_eq("t3_period",    last_per, 10);
      end
      if (i == 39) check_eq("t3_no_spd", spd_cnt, 0);
      if (i == 40) begin
        check_eq("t3_spd_cnt", spd_cnt, 1);
        check_eq("t3_speed",   last_spd, 2);
        check_eq("t3_jumps",   jmp_cnt, 1);
      end
      case (i)
        4:  cnt = 12'd51;
        9:  cnt = 12'd2000;
        14: cnt = 12'd2001;
        24: cnt = 12'd2002;
        default: ;
      endcase
      bus.CNT_IN = cnt;
    end

    // Stall: pcnt saturates at 255 in this build.
    cnt++; bus.CNT_IN = cnt;
    tick();
    check_eq("t4_pre_period", bus.PERIOD_OUT, 16);
    repeat (253) tick();
    check_eq("t4_stall_254", bus.STALL_OUT, 0);
    tick();
    check_eq("t4_stall_255", bus.STALL_OUT, 1);
    repeat (10) tick();
    check_eq("t4_stall_hold", bus.STALL_OUT, 1);
    cnt++; bus.CNT_IN = cnt;
    tick();
    check_eq("t4_period_sat", bus.PERIOD_OUT, 255);
    check_eq("t4_pvld",       bus.PERIOD_VALID, 1);
    check_eq("t4_stall_clr",  bus.STALL_OUT, 0);
    bus.EN_IN = 1'b0;
    tick();

    // Zero window means every cycle; window length change takes effect next window.
    bus.WINDOW_CYCLES = 16'd0;
    bus.EN_IN = 1'b1;
    tick();
    clr_stats();
    repeat (5) tick();
    check_eq("t5_every_cycle", spd_cnt, 5);
    bus.EN_IN = 1'b0;
    tick();
    bus.WINDOW_CYCLES = 16'd20;
    bus.EN_IN = 1'b1;
    tick();
    clr_stats();
    repeat (5) tick();
    bus.WINDOW_CYCLES = 16'd50;
    repeat (14) tick();
    check_eq("t5_win20_early", spd_cnt, 0);
    tick();
    check_eq("t5_win20_end", spd_cnt, 1);
    repeat (49) tick();
    check_eq("t5_win50_early", spd_cnt, 1);
    tick();
    check_eq("t5_win50_end", spd_cnt, 2);
    bus.EN_IN = 1'b0;
    tick();

    // Clear during a pending window, then a fresh window from the new count.
    bus.WINDOW_CYCLES = 16'd4;
    bus.EN_IN = 1'b1;
    tick();
    clr_stats();
    cnt++; bus.CNT_IN = cnt; tick();
    cnt++; bus.CNT_IN = cnt; tick();
    repeat (2) tick();
    check_eq("t6_pre_speed", last_spd, 2);
    repeat (2) tick();
    cnt = 12'd3000; bus.CNT_IN = cnt;
    bus.CLR_IN = 1'b1;
    tick();
    check_all_zero("t6_clr");
    bus.CLR_IN = 1'b0;
    bus.WINDOW_CYCLES = 16'd6;
    clr_stats();
    tick();
    cnt++; bus.CNT_IN = cnt; tick();
    cnt++; bus.CNT_IN = cnt;
    repeat (4) tick();
    check_eq("t6_no_spd", spd_cnt, 0);
    tick();
    check_eq("t6_spd_cnt", spd_cnt, 1);
    check_eq("t6_speed",   last_spd, 2);
    check_eq("t6_jumps",   jmp_cnt, 0);

    // Asynchronous reset mid-window.
    repeat (2) tick();
    ARSTN = 1'b0;
    #2;
    check_all_zero("t6_arst");
    ARSTN = 1'b1;
    clr_stats();
    repeat (6) tick();
    check_eq("t6_arst_no_spd", spd_cnt, 0);
    tick();
    check_eq("t6_arst_spd",   spd_cnt, 1);
    check_eq("t6_arst_speed", last_spd, 0);
    check_eq("t6_arst_jumps", jmp_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
